// File: rtl/io_project_mux.sv
// Runtime-selectable pad multiplexer: N_PROJ user projects share one bank of Caravel pads.
// A Wishbone write picks the project; pads tristate for GUARD_CYCLES while every project sits in reset.
module io_project_mux #(
  parameter int          N_PROJ       = 4,
  parameter int          N_PADS       = 38,
  parameter int          GUARD_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  input  logic [N_PADS-1:0]        io_in,
  output logic [N_PADS-1:0]        io_out,
  output logic [N_PADS-1:0]        io_oeb,
  output logic [N_PROJ*N_PADS-1:0] proj_io_in,
  input  logic [N_PROJ*N_PADS-1:0] proj_io_out,
  input  logic [N_PROJ*N_PADS-1:0] proj_io_oeb,
  output logic [N_PROJ-1:0]        proj_rst_no,
  output logic                     switch_irq_o
);

  localparam int HI_W = N_PADS - 32;

  typedef enum logic [1:0] {IDLE = 2'd0, GUARD = 2'd1, ACTIVE = 2'd2} state_t;

  // Bus decode
  logic        req, ack_q, mapped, wr, ctrl_wr;
  logic [1:0]  off;
  logic [31:0] rdata, dat_q;
  logic [3:0]  ctrl_sel_q, new_sel;
  logic        ctrl_en_q, new_en, sel_valid;
  logic [31:0]     mask_lo_q;
  logic [HI_W-1:0] mask_hi_q;

  // FSM state
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  target_q, target_d, asel_q, asel_d;
  logic        tvld_q, tvld_d, err_q, err_d, irq_q, irq_d;
  logic [N_PROJ-1:0] proj_en_q, proj_en_d;

  assign req     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign mapped  = (wbs_adr_i[7:4] == 4'd0) && (wbs_adr_i[1:0] == 2'd0);
  assign off     = wbs_adr_i[3:2];
  // A write commits on the clock edge that closes its ack cycle.
  assign wr      = req & ack_q & wbs_we_i & mapped;
  assign ctrl_wr = wr && (off == 2'd0);

  assign new_sel   = wbs_sel_i[0] ? wbs_dat_i[3:0] : ctrl_sel_q;
  assign new_en    = wbs_sel_i[1] ? wbs_dat_i[8]   : ctrl_en_q;
  assign sel_valid = {1'b0, new_sel} < 5'(N_PROJ);

  always_comb begin
    rdata = '0;
    if (mapped) begin
      unique case (off)
        2'd0: rdata = {23'd0, ctrl_en_q, 4'd0, ctrl_sel_q};
        2'd1: rdata = {23'd0, err_q, asel_q, 2'd0, state_q};
        2'd2: rdata = mask_lo_q;
        2'd3: rdata = 32'(mask_hi_q);
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      ctrl_sel_q <= '0;
      ctrl_en_q  <= 1'b0;
      mask_lo_q  <= '0;
      mask_hi_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      ack_q <= req & ~ack_q;
      dat_q <= (req & ~ack_q & ~wbs_we_i) ? rdata : 32'd0;
      if (ctrl_wr) begin
        ctrl_sel_q <= new_sel;
        ctrl_en_q  <= new_en;
      end
      if (wr && off == 2'd2)
        for (int b = 0; b < 4; b++)
          if (wbs_sel_i[b]) mask_lo_q[8*b +: 8] <= wbs_dat_i[8*b +: 8];
      if (wr && off == 2'd3)
        for (int i = 0; i < HI_W; i++)
          if (wbs_sel_i[i/8]) mask_hi_q[i] <= wbs_dat_i[i];
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    tvld_d   = tvld_q;
    asel_d   = asel_q;
    err_d    = err_q;
    irq_d    = 1'b0;

    if (state_q == GUARD) begin
      if (cnt_q == 8'd0) begin
        if (tvld_q) begin
          state_d = ACTIVE;
          asel_d  = target_q;
          irq_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end

    // A CTRL write always restarts the guard, even mid-guard or re-selecting the same project.
    if (ctrl_wr) begin
      state_d  = GUARD;
      cnt_d    = 8'(GUARD_CYCLES - 1);
      irq_d    = 1'b0;
      target_d = new_sel;
      tvld_d   = new_en && sel_valid;
      if (new_en) err_d = !sel_valid;
    end

    for (int k = 0; k < N_PROJ; k++)
      proj_en_d[k] = (state_d == ACTIVE) && (asel_d == 4'(k));
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      target_q  <= '0;
      tvld_q    <= 1'b0;
      asel_q    <= '0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
      proj_en_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      tvld_q    <= tvld_d;
      asel_q    <= asel_d;
      err_q     <= err_d;
      irq_q     <= irq_d;
      proj_en_q <= proj_en_d;
    end
  end

  assign switch_irq_o = irq_q;
  assign proj_rst_no  = proj_en_q;

  // Pad path is an AND-OR mux on the registered one-hot, so it stays glitch-free across switches.
  always_comb begin
    logic [N_PADS-1:0] out_mux, oeb_mux;
    out_mux    = '0;
    oeb_mux    = '0;
    proj_io_in = '0;
    for (int k = 0; k < N_PROJ; k++) begin
      if (proj_en_q[k]) begin
        out_mux |= proj_io_out[k*N_PADS +: N_PADS];
        oeb_mux |= proj_io_oeb[k*N_PADS +: N_PADS];
        proj_io_in[k*N_PADS +: N_PADS] = io_in;
      end
    end
    io_out = out_mux;
    io_oeb = (|proj_en_q) ? (oeb_mux | {mask_hi_q, mask_lo_q}) : '1;
  end

endmodule

// File: tb/tb_io_project_mux.sv
// Self-checking bench for io_project_mux: register vectors through a read scoreboard,
// plus hand-written switch, guard-restart, bad-select, mask and reset sequences.
module tb_io_project_mux;

  localparam int          NP    = 4;
  localparam int          NPADS = 38;
  localparam int          GC    = 16;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic                    clk, rst_n;
  logic                    stb, cyc, we;
  logic [3:0]              sel;
  logic [31:0]             adr, dat_i, dat_o;
  logic                    ack;
  logic [NPADS-1:0]        io_in, io_out, io_oeb;
  logic [NP*NPADS-1:0]     proj_io_in, proj_io_out, proj_io_oeb;
  logic [NP-1:0]           proj_rst_no;
  logic                    irq;

  io_project_mux #(.N_PROJ(NP), .N_PADS(NPADS), .GUARD_CYCLES(GC), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .proj_io_in(proj_io_in), .proj_io_out(proj_io_out), .proj_io_oeb(proj_io_oeb),
    .proj_rst_no(proj_rst_no), .switch_irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [NPADS-1:0] tb_mask;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the ack cycle (first cycle after commit).
  task automatic bus(input logic [7:0] off, input logic w, input logic [31:0] d, input logic [3:0] s);
    int n;
    adr = BASE | 32'(off); we = w; dat_i = d; sel = s; stb = 1'b1; cyc = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 4);
    check($sformatf("ack_latency_%0h", off), 256'(n), 256'(1));
    if (ack && !w) begin
      if (exp_q.size() == 0) check("scoreboard_underflow", 256'(1), 256'(0));
      else check($sformatf("read_%0h", off), 256'(dat_o), 256'(exp_q.pop_front()));
    end
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0;
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] e);
    exp_q.push_back(e);
    bus(off, 1'b0, 32'd0, 4'hF);
  endtask

  function automatic logic [NPADS-1:0] slice(input logic [NP*NPADS-1:0] v, input int a);
    return v[a*NPADS +: NPADS];
  endfunction

  task automatic check_active(input int a, input string tag);
    logic [NP*NPADS-1:0] exp_in;
    exp_in = '0;
    exp_in[a*NPADS +: NPADS] = io_in;
    check({tag, "_rst"},   256'(proj_rst_no), 256'(4'(1 << a)));
    check({tag, "_out"},   256'(io_out), 256'(slice(proj_io_out, a)));
    check({tag, "_oeb"},   256'(io_oeb), 256'(slice(proj_io_oeb, a) | tb_mask));
    check({tag, "_in"},    256'(proj_io_in), 256'(exp_in));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_oeb"}, 256'(io_oeb), 256'({NPADS{1'b1}}));
    check({tag, "_out"}, 256'(io_out), 256'(0));
    check({tag, "_rst"}, 256'(proj_rst_no), 256'(0));
    check({tag, "_in"},  256'(proj_io_in), 256'(0));
  endtask

  // Count guard cycles from the first guard sample until a project is released.
  task automatic wait_active(input int a, input string tag);
    int n, irqs;
    n = 0; irqs = 0;
    while (proj_rst_no == '0 && n < 200) begin
      if (irq) irqs++;
      n++;
      @(negedge clk);
    end
    check({tag, "_guard_len"}, 256'(n), 256'(GC));
    check({tag, "_irq_early"}, 256'(irqs), 256'(0));
    check({tag, "_irq"}, 256'(irq), 256'(1));
    check_active(a, tag);
    @(negedge clk);
    check({tag, "_irq_one_cycle"}, 256'(irq), 256'(0));
  endtask

  typedef struct {
    logic [7:0]  off;
    logic        w;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] e;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int bad, irqs;
    logic [5:0] pat;

    vecs[0]  = '{8'h00, 1'b0, 32'h0,         4'hF, 32'h0};
    vecs[1]  = '{8'h04, 1'b0, 32'h0,         4'hF, 32'h0};
    vecs[2]  = '{8'h08, 1'b1, 32'hA5A5_5A5A, 4'hF, 32'h0};
    vecs[3]  = '{8'h08, 1'b0, 32'h0,         4'hF, 32'hA5A5_5A5A};
    vecs[4]  = '{8'h08, 1'b1, 32'h1234_5678, 4'h5, 32'h0};
    vecs[5]  = '{8'h08, 1'b0, 32'h0,         4'hF, 32'hA534_5A78};
    vecs[6]  = '{8'h0C, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[7]  = '{8'h0C, 1'b0, 32'h0,         4'hF, 32'h0000_003F};
    vecs[8]  = '{8'h0C, 1'b1, 32'h0,         4'hE, 32'h0};
    vecs[9]  = '{8'h0C, 1'b0, 32'h0,         4'hF, 32'h0000_003F};
    vecs[10] = '{8'h10, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[11] = '{8'h10, 1'b0, 32'h0,         4'hF, 32'h0};
    vecs[12] = '{8'h04, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[13] = '{8'h04, 1'b0, 32'h0,         4'hF, 32'h0};
    vecs[14] = '{8'h08, 1'b1, 32'h0,         4'hF, 32'h0};
    vecs[15] = '{8'h0C, 1'b1, 32'h0,         4'hF, 32'h0};
    vecs[16] = '{8'h08, 1'b0, 32'h0,         4'hF, 32'h0};
    vecs[17] = '{8'h0C, 1'b0, 32'h0,         4'hF, 32'h0};

    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_i = '0;
    tb_mask = '0;
    for (int i = 0; i < NP*NPADS; i++) begin
      proj_io_out[i] = 1'($urandom_range(0, 1));
      proj_io_oeb[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < NPADS; i++) io_in[i] = 1'($urandom_range(0, 1));

    repeat (3) @(negedge clk);
    check_idle("in_reset");
    check("in_reset_irq", 256'(irq), 256'(0));
    check("in_reset_ack", 256'(ack), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_reset");

    // Register map vectors
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].w) bus(vecs[i].off, 1'b1, vecs[i].d, vecs[i].s);
      else rd(vecs[i].off, vecs[i].e);
    end
    check("regs_no_switch_rst", 256'(proj_rst_no), 256'(0));

    // Select project 2
    bus(8'h00, 1'b1, 32'h0000_0102, 4'h3);
    check("sel2_guard_rst", 256'(proj_rst_no), 256'(0));
    wait_active(2, "sel2");
    rd(8'h04, 32'h0000_0022);
    rd(8'h00, 32'h0000_0102);
    io_in = ~io_in;
    #1 check_active(2, "sel2_new_in");

    // Switch 2 -> 1: pads tristate on the cycle after the ack
    bus(8'h00, 1'b1, 32'h0000_0101, 4'hF);
    check_idle("sw21_ack1");
    wait_active(1, "sel1");

    // Guard restart: 0x103 then 0x100 five cycles later
    bus(8'h00, 1'b1, 32'h0000_0103, 4'hF);
    bad = 0;
    repeat (5) begin
      if (proj_rst_no != '0 || irq) bad++;
      @(negedge clk);
    end
    check("restart_first_guard", 256'(bad), 256'(0));
    bus(8'h00, 1'b1, 32'h0000_0100, 4'hF);
    wait_active(0, "restart");
    rd(8'h04, 32'h0000_0002);

    // Out-of-range select
    bus(8'h00, 1'b1, 32'h0000_0107, 4'hF);
    bad = 0; irqs = 0;
    repeat (25) begin
      if (proj_rst_no != '0) bad++;
      if (irq) irqs++;
      @(negedge clk);
    end
    check("badsel_no_release", 256'(bad), 256'(0));
    check("badsel_no_irq", 256'(irqs), 256'(0));
    check_idle("badsel_idle");
    rd(8'h04, 32'h0000_0100);
    bus(8'h00, 1'b1, 32'h0000_0100, 4'hF);
    wait_active(0, "clr_err");
    rd(8'h04, 32'h0000_0002);

    // Forced-input masks in ACTIVE
    proj_io_oeb = '0;
    #1 check_active(0, "mask_before");
    bus(8'h08, 1'b1, 32'h0000_00F0, 4'hF);
    tb_mask = 38'h00_0000_00F0;
    check("mask_lo_oeb", 256'(io_oeb), 256'(38'h00_0000_00F0));
    bus(8'h0C, 1'b1, 32'h0000_0001, 4'h1);
    tb_mask = 38'h01_0000_00F0;
    check_active(0, "mask_hi");
    rd(8'h04, 32'h0000_0002);

    // Reset pulse mid-guard
    bus(8'h00, 1'b1, 32'h0000_0101, 4'hF);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst");
    check("async_rst_irq", 256'(irq), 256'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tb_mask = '0;
    rd(8'h08, 32'h0);
    rd(8'h0C, 32'h0);
    rd(8'h00, 32'h0);
    rd(8'h04, 32'h0);
    bad = 0;
    repeat (20) begin
      if (proj_rst_no != '0 || irq) bad++;
      @(negedge clk);
    end
    check("post_rst_stays_idle", 256'(bad), 256'(0));

    // Held request acks every second cycle; dat_o is 0 outside ack
    adr = BASE | 32'h4; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    pat = '0; bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[5-i] = ack;
      if (!ack && dat_o != '0) bad++;
    end
    stb = 1'b0; cyc = 1'b0;
    check("held_ack_pattern", 256'(pat), 256'(6'b101010));
    check("dat_zero_without_ack", 256'(bad), 256'(0));

    // Address outside the window gets no ack
    @(negedge clk);
    adr = BASE + 32'h100; stb = 1'b1; cyc = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack) bad++;
    end
    stb = 1'b0; cyc = 1'b0;
    check("nomatch_no_ack", 256'(bad), 256'(0));

    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
